muldiv_unit: RTL and testbench
==============================

# muldiv_unit

- Iterative RV32M multiply/divide execution unit.
- Sits between register-file read and writeback:
  - Consumes the two read operands.
  - Computes one of the eight M-extension operations over a fixed number of cycles.
  - Produces a single-cycle write request (`rd`, `we`, `wdata`) that drives the register file write port directly.
- Decode holds the pipeline while `busy` is high.

## Interface

Parameters:
- `XLEN`, default 32: datapath width. Only 32 is supported and verified.

Ports:
- `clk`, input, 1: clock. All state changes occur at the posedge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a new operation. Sampled only in IDLE.
- `flush`, input, 1: synchronous abort of any in-flight operation.
- `funct3`, input, 3: operation select.
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `rd_in`, input, 5: destination register of the request.
- `op_a`, input, 32: rs1 value (dividend / multiplicand).
- `op_b`, input, 32: rs2 value (divisor / multiplier).
- `busy`, output, 1: high whenever state ≠ IDLE.
- `done`, output, 1: one-cycle pulse when the result is valid.
- `rd`, output, 5: destination register, valid with `done`.
- `we`, output, 1: register-file write enable, equal to `done && rd != 0`.
- `wdata`, output, 32: result, valid with `done`.

## Operation

- **States:** IDLE → RUN → DONE → IDLE.
- **IDLE:**
  - On `start=1` (and `flush=0`), latch `funct3` and `rd_in`.
  - Convert operands to magnitudes:
    - Signed operands: MUL/MULH both operands; MULHSU `op_a` only; DIV/REM both operands.
  - Record the result sign:
    - Product: sign_a XOR sign_b.
    - Quotient: sign_a XOR sign_b.
    - Remainder: sign_a.
  - Clear the 6-bit iteration counter and go to RUN.
- **RUN, multiply:** 32 shift-add steps on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- **RUN, divide:** 32 restoring-division steps, one quotient bit per cycle, MSB first, on a 33-bit partial remainder.
- **Leaving RUN:** after counter reaches 31 (32 iterations), go to DONE.
- **DONE:**
  - Apply sign correction (two's-complement negate when the sign flag is set).
  - Select the result:
    - MUL: low 32 bits of the product.
    - MULH/MULHSU/MULHU: high 32 bits of the product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register `wdata`, assert `done` for exactly one cycle, return to IDLE.
- **Divide by zero** (`op_b=0`): same latency.
  - Quotient = 0xFFFFFFFF for both DIV and DIVU.
  - Remainder = `op_a` unmodified.
- **Signed overflow** (DIV/REM, `op_a`=0x80000000, `op_b`=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- **`rd_in=0`:** operation runs and `done` pulses, but `we` stays 0.
- **`start` while busy:** ignored. No queuing, no effect on the in-flight operation.
- **`flush=1` in any state:** next edge forces IDLE; `done`/`we` stay 0 and no write occurs. `flush` has priority over `start`.

## Timing

- **Reset:** while `reset=1`, asynchronously:
  - State = IDLE, counter = 0.
  - `busy`=0, `done`=0, `we`=0, `rd`=0, `wdata`=0.
- **Latency:** `start` is sampled at edge E0.
  - `busy`=1 from E0 through E33.
  - Iterations occur at E1..E32.
  - `done`/`we`/`wdata`/`rd` are valid for the cycle between E33 and E34.
  - `busy`=0 after E34.
- **Back-to-back:** earliest next accepted `start` is at E34 (34-cycle initiation interval).
- **Operand capture:** `op_a`/`op_b`/`funct3`/`rd_in` need only be stable at E0; later changes are ignored.
- **Output hold:** `wdata` and `rd` hold their value after `done` falls until the next DONE. `done` and `we` are 0 outside DONE.
- **Reset mid-operation:** immediate abort, no write. The first `start` after reset deasserts behaves normally.

## Test plan

- **Reset and basic multiply:** apply reset; check all outputs 0. Then MUL, `op_a`=7, `op_b`=0xFFFFFFFD, `rd_in`=5 → `wdata`=0xFFFFFFEB, `rd`=5, `we`=1 exactly at E33. `busy` falls after E34.
- **High-half multiplies:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Divide/remainder:**
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- **Divide corner cases:**
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- **Handshake corners:**
  - `start` pulsed at E10 of a running op → ignored; the original result is unchanged.
  - MUL 3×4 with `rd_in`=0 → `done`=1, `wdata`=12, `we`=0.
- **Abort:**
  - `reset` at iteration 10 → `busy`, `done`, `we` drop immediately, no write. A following DIVU 9/3 returns 3 at E33.
  - `flush` at iteration 20 → IDLE next edge, no `done`.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between decode, the multiply/divide unit and the register-file write port.
// The master drives the request; the slave (the unit) returns status and the write request.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [4:0]      rd_in;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] wdata;

    modport master (
        output start, flush, funct3, rd_in, op_a, op_b,
        input  busy, done, rd, we, wdata
    );

    modport slave (
        input  start, flush, funct3, rd_in, op_a, op_b,
        output busy, done, rd, we, wdata
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-division steps on operand
// magnitudes, sign fix-up in DONE, then a single-cycle register-file write request.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic         clk,
    input logic         reset,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state;
    logic [5:0]      cnt;
    logic [2:0]      f3;
    logic [4:0]      rd_lat;
    logic            neg;
    logic [XLEN-1:0] mag;      // multiplicand for MUL*, divisor for DIV*
    logic [2*XLEN-1:0] acc;    // product, or dividend/quotient in the low half
    logic [XLEN-1:0] rem;

    logic            signed_a, signed_b, a_neg, b_neg, start_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN:0]   mul_sum, div_shift;
    logic [XLEN-1:0] div_sub;
    logic            div_ge;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo, rmd, result;

    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (bus.funct3)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            3'd2:    signed_a = 1'b1;
            default: ;
        endcase
        a_neg = signed_a & bus.op_a[XLEN-1];
        b_neg = signed_b & bus.op_b[XLEN-1];
        a_abs = a_neg ? -bus.op_a : bus.op_a;
        b_abs = b_neg ? -bus.op_b : bus.op_b;
        // A zero divisor must yield all-ones for DIV too, so never negate that quotient.
        if (bus.funct3[2] && bus.funct3[1]) begin
            start_neg = a_neg;
        end else if (bus.funct3[2]) begin
            start_neg = (a_neg ^ b_neg) & (bus.op_b != '0);
        end else begin
            start_neg = a_neg ^ b_neg;
        end

        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag} : '0);
        div_shift = {rem, acc[XLEN-1]};
        div_ge    = div_shift >= {1'b0, mag};
        div_sub   = div_shift[XLEN-1:0] - mag;

        prod = neg ? -acc : acc;
        quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rmd  = neg ? -rem : rem;
        case (f3)
            3'd0:             result = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: result = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       result = quo;
            default:          result = rmd;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            cnt       <= '0;
            f3        <= '0;
            rd_lat    <= '0;
            neg       <= 1'b0;
            mag       <= '0;
            acc       <= '0;
            rem       <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.we    <= 1'b0;
            bus.rd    <= '0;
            bus.wdata <= '0;
        end else if (bus.flush) begin
            state    <= StIdle;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.we   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    bus.done <= 1'b0;
                    bus.we   <= 1'b0;
                    bus.busy <= bus.start;
                    if (bus.start) begin
                        state  <= StRun;
                        cnt    <= '0;
                        f3     <= bus.funct3;
                        rd_lat <= bus.rd_in;
                        neg    <= start_neg;
                        rem    <= '0;
                        mag    <= bus.funct3[2] ? b_abs : a_abs;
                        acc    <= {{XLEN{1'b0}}, (bus.funct3[2] ? a_abs : b_abs)};
                    end
                end
                StRun: begin
                    if (f3[2]) begin
                        rem <= div_ge ? div_sub : div_shift[XLEN-1:0];
                        acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    // busy stays high through the result cycle; IDLE clears it a cycle later.
                    bus.wdata <= result;
                    bus.rd    <= rd_lat;
                    bus.done  <= 1'b1;
                    bus.we    <= (rd_lat != 5'd0);
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: an arithmetic reference model with per-cycle output checking, directed
// corner cases with literal results, then randomized operations with ignored-start noise.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [2:0] f, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0]     p;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Reference model: tracks acceptance, due cycle and held outputs; checks every cycle.
    int          cycle = 0;
    int          c0 = 0;
    int          exp_due = 0;
    bit          active = 1'b0;
    bit          exp_valid = 1'b0;
    logic [4:0]  exp_rd = '0, last_rd = '0;
    logic [31:0] exp_wd = '0, last_wd = '0;

    initial forever begin
        @(posedge clk);
        cycle++;
        if (reset) begin
            active = 1'b0;
            exp_valid = 1'b0;
            last_rd = '0;
            last_wd = '0;
        end else if (bus.flush) begin
            active = 1'b0;
            exp_valid = 1'b0;
        end else if (bus.start && !(active && cycle <= c0 + 33)) begin
            active = 1'b1;
            c0 = cycle;
            exp_valid = 1'b1;
            exp_due = cycle + 33;
            exp_rd = bus.rd_in;
            exp_wd = model_result(bus.funct3, bus.op_a, bus.op_b);
        end
        #1;
        if (exp_valid && cycle == exp_due) begin
            chk("done", {31'b0, bus.done}, 32'd1);
            chk("we", {31'b0, bus.we}, {31'b0, exp_rd != 5'd0});
            chk("rd", {27'b0, bus.rd}, {27'b0, exp_rd});
            chk("wdata", bus.wdata, exp_wd);
            last_rd = exp_rd;
            last_wd = exp_wd;
            exp_valid = 1'b0;
        end else begin
            chk("done_idle", {31'b0, bus.done}, 32'd0);
            chk("we_idle", {31'b0, bus.we}, 32'd0);
            chk("rd_hold", {27'b0, bus.rd}, {27'b0, last_rd});
            chk("wdata_hold", bus.wdata, last_wd);
        end
        chk("busy", {31'b0, bus.busy}, {31'b0, active && cycle <= c0 + 33});
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r);
        @(negedge clk);
        bus.start = 1'b1;
        bus.funct3 = f;
        bus.op_a = a;
        bus.op_b = b;
        bus.rd_in = r;
        @(negedge clk);
        bus.start = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.op_a = $urandom;
        bus.op_b = $urandom;
        bus.rd_in = 5'($urandom);
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL %s: got no done within 40 cycles expected done", name);
        end
    endtask

    task automatic run_lit(input string name, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp);
        int n;
        issue(f, a, b, r);
        wait_done(name, n);
        if (n < 40) chk(name, bus.wdata, exp);
    endtask

    initial begin
        int n;
        int seen;
        logic [2:0]  f;
        logic [31:0] a, b;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.funct3 = '0;
        bus.rd_in = '0;
        bus.op_a = '0;
        bus.op_b = '0;

        @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_we", {31'b0, bus.we}, 32'd0);
        chk("rst_rd", {27'b0, bus.rd}, 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        reset = 1'b0;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        wait_done("mul_basic", n);
        chk("mul_latency", n, 32'd33);
        chk("mul_basic", bus.wdata, 32'hFFFF_FFEB);
        chk("mul_rd", {27'b0, bus.rd}, 32'd5);
        chk("mul_we", {31'b0, bus.we}, 32'd1);
        @(negedge clk);
        chk("mul_busy_fall", {31'b0, bus.busy}, 32'd0);

        run_lit("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
        run_lit("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
        run_lit("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
        run_lit("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
        run_lit("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
        run_lit("divu", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14);
        run_lit("remu", 3'd7, 32'd100, 32'd7, 5'd8, 32'd2);
        run_lit("div_by0", 3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF);
        run_lit("remu_by0", 3'd7, 32'd5, 32'd0, 5'd10, 32'd5);
        run_lit("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
        run_lit("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);

        // A start pulse mid-operation must not disturb the running MUL.
        issue(3'd0, 32'd1000, 32'd1000, 5'd13);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.funct3 = 3'd5;
        bus.op_a = 32'd77;
        bus.op_b = 32'd3;
        bus.rd_in = 5'd14;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("start_busy", n);
        chk("start_busy", bus.wdata, 32'd1_000_000);
        chk("start_busy_rd", {27'b0, bus.rd}, 32'd13);

        run_lit("mul_rd0", 3'd0, 32'd3, 32'd4, 5'd0, 32'd12);
        chk("mul_rd0_done", {31'b0, bus.done}, 32'd1);
        chk("mul_rd0_we", {31'b0, bus.we}, 32'd0);

        issue(3'd0, 32'd123, 32'd456, 5'd15);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_mid_done", {31'b0, bus.done}, 32'd0);
        chk("rst_mid_we", {31'b0, bus.we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(3'd5, 32'd9, 32'd3, 5'd16);
        wait_done("divu_after_rst", n);
        chk("divu_after_rst_lat", n, 32'd33);
        chk("divu_after_rst", bus.wdata, 32'd3);

        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17);
        repeat (19) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", {31'b0, bus.busy}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        chk("flush_no_done", seen, 32'd0);

        for (int i = 0; i < 200; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 50); b = $urandom_range(0, 9); end
                3: b = $urandom_range(1, 15);
                default: ;
            endcase
            issue(f, a, b, 5'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 25)) @(negedge clk);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
            wait_done("random", n);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
